// File: rtl/exc_ctrl_pkg.sv
// rtl/exc_ctrl_pkg.sv - shared exception codes, CP0 addresses, flag indices and priority select
package exc_ctrl_pkg;

  localparam int DATA_W     = 32;
  localparam int HARD_INT_W = 6;

  localparam logic [DATA_W-1:0] ZERO_WORD      = 32'h0000_0000;
  localparam logic [DATA_W-1:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  localparam logic [DATA_W-1:0] EXCT_INT  = 32'h0000_0001;
  localparam logic [DATA_W-1:0] EXCT_ADEL = 32'h0000_0004;
  localparam logic [DATA_W-1:0] EXCT_ADES = 32'h0000_0005;
  localparam logic [DATA_W-1:0] EXCT_SYS  = 32'h0000_0008;
  localparam logic [DATA_W-1:0] EXCT_BP   = 32'h0000_0009;
  localparam logic [DATA_W-1:0] EXCT_RI   = 32'h0000_000a;
  localparam logic [DATA_W-1:0] EXCT_OV   = 32'h0000_000c;
  localparam logic [DATA_W-1:0] EXCT_ERET = 32'h0000_000e;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;

  localparam int FLAG_ADEL_IF = 0;
  localparam int FLAG_RI      = 1;
  localparam int FLAG_OV      = 2;
  localparam int FLAG_SYS     = 3;
  localparam int FLAG_BP      = 4;
  localparam int FLAG_ADEL_D  = 5;
  localparam int FLAG_ADES    = 6;
  localparam int FLAG_ERET    = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Fixed priority: a pending interrupt beats every synchronous exception.
  function automatic logic [DATA_W-1:0] sel_exc(input logic int_pend, input logic [7:0] f);
    logic [DATA_W-1:0] code;
    code = ZERO_WORD;
    if (int_pend)                code = EXCT_INT;
    else if (f[FLAG_ADEL_IF])    code = EXCT_ADEL;
    else if (f[FLAG_RI])         code = EXCT_RI;
    else if (f[FLAG_OV])         code = EXCT_OV;
    else if (f[FLAG_SYS])        code = EXCT_SYS;
    else if (f[FLAG_BP])         code = EXCT_BP;
    else if (f[FLAG_ADEL_D])     code = EXCT_ADEL;
    else if (f[FLAG_ADES])       code = EXCT_ADES;
    else if (f[FLAG_ERET])       code = EXCT_ERET;
    return code;
  endfunction

endpackage

// File: rtl/exc_timer.sv
// rtl/exc_timer.sv - CP0 count/compare timer, used only when EXC_CTRL_TIMER_EN is defined
module exc_timer
  import exc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cp0_we,
  input  logic [4:0]        cp0_waddr,
  input  logic [DATA_W-1:0] cp0_wdata,
  output logic              timer_int
);

  logic              half_q;
  logic [DATA_W-1:0] count_q;
  logic [DATA_W-1:0] compare_q;
  logic              int_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half_q    <= 1'b0;
      count_q   <= ZERO_WORD;
      compare_q <= ZERO_WORD;
      int_q     <= 1'b0;
    end else begin
      half_q <= ~half_q;
      if (cp0_we && cp0_waddr == CP0_COUNT) begin
        count_q <= cp0_wdata;
      end else if (half_q) begin
        count_q <= count_q + 32'd1;
      end
      // A compare write both reloads the match value and acknowledges the interrupt.
      if (cp0_we && cp0_waddr == CP0_COMPARE) begin
        compare_q <= cp0_wdata;
        int_q     <= 1'b0;
      end else if (compare_q != ZERO_WORD && count_q == compare_q) begin
        int_q <= 1'b1;
      end
    end
  end

  assign timer_int = int_q;

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt select and flush/redirect sequencer; option EXC_CTRL_TIMER_EN adds count/compare
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [DATA_W-1:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int unsigned       FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic [7:0]            mem_excflags,
  input  logic [DATA_W-1:0]     mem_badaddr,
  input  logic [HARD_INT_W-1:0] hw_intr,
  input  logic [DATA_W-1:0]     status,
  input  logic [DATA_W-1:0]     cause,
  input  logic [DATA_W-1:0]     epc,
`ifdef EXC_CTRL_TIMER_EN
  input  logic                  cp0_we,
  input  logic [4:0]            cp0_waddr,
  input  logic [DATA_W-1:0]     cp0_wdata,
`endif
  output logic [DATA_W-1:0]     exctype,
  output logic [HARD_INT_W-1:0] intr,
  output logic                  flush,
  output logic                  new_pc_valid,
  output logic [DATA_W-1:0]     new_pc,
  output logic                  busy
);

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_W-1:0]     pc_q, pc_d;
  logic                  pcv_q, pcv_d;
  logic [HARD_INT_W-1:0] sync1_q, sync2_q;
  logic                  int_pend;
  logic                  accept;
  logic [DATA_W-1:0]     sel_code;
  logic                  unused_sig;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= hw_intr;
      sync2_q <= sync1_q;
    end
  end

`ifdef EXC_CTRL_TIMER_EN
  logic timer_int;

  exc_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .cp0_we    (cp0_we),
    .cp0_waddr (cp0_waddr),
    .cp0_wdata (cp0_wdata),
    .timer_int (timer_int)
  );

  assign intr = {sync2_q[5] | timer_int, sync2_q[4:0]};
`else
  assign intr = sync2_q;
`endif

  assign int_pend = status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));

  // Only an idle controller with a valid MEM instruction may raise a code; rst gates it so reset reads ZeroWord.
  always_comb begin
    sel_code = ZERO_WORD;
    if (rst && state_q == ST_IDLE && mem_valid) begin
      sel_code = sel_exc(int_pend, mem_excflags);
    end
  end

  assign exctype = sel_code;
  assign accept  = (sel_code != ZERO_WORD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    pcv_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_INIT;
          pcv_d   = 1'b1;
          pc_d    = (sel_code == EXCT_ERET) ? epc : EXC_VECTOR;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      pc_q    <= ZERO_WORD;
      pcv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      pcv_q   <= pcv_d;
    end
  end

  assign flush        = (state_q == ST_FLUSH);
  assign busy         = (state_q != ST_IDLE);
  assign new_pc_valid = pcv_q;
  assign new_pc       = pc_q;

  // Bad address is routed to CP0 elsewhere; remaining Status/Cause bits are not needed here.
  assign unused_sig = ^{mem_badaddr, status[31:16], status[7:2], cause[31:16], cause[7:0]};

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed self-checking bench for exc_ctrl
module tb_exc_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic [7:0]  mem_excflags;
  logic [31:0] mem_badaddr;
  logic [5:0]  hw_intr;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic [31:0] exctype;
  logic [5:0]  intr;
  logic        flush;
  logic        new_pc_valid;
  logic [31:0] new_pc;
  logic        busy;

  int n_cmp;
  int n_fail;

  localparam logic [31:0] E_INT  = 32'h1;
  localparam logic [31:0] E_ADEL = 32'h4;
  localparam logic [31:0] E_ADES = 32'h5;
  localparam logic [31:0] E_SYS  = 32'h8;
  localparam logic [31:0] E_BP   = 32'h9;
  localparam logic [31:0] E_RI   = 32'ha;
  localparam logic [31:0] E_OV   = 32'hc;
  localparam logic [31:0] E_ERET = 32'he;
  localparam logic [31:0] VEC    = 32'hBFC0_0380;

  exc_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem_valid    (mem_valid),
    .mem_excflags (mem_excflags),
    .mem_badaddr  (mem_badaddr),
    .hw_intr      (hw_intr),
    .status       (status),
    .cause        (cause),
    .epc          (epc),
    .exctype      (exctype),
    .intr         (intr),
    .flush        (flush),
    .new_pc_valid (new_pc_valid),
    .new_pc       (new_pc),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one event at T and checks the redirect/flush window T+1..T+3.
  task automatic accept_chk(input string tag, input logic [7:0] f, input logic [31:0] code,
                            input logic [31:0] pc);
    @(negedge clk); mem_valid = 1'b1; mem_excflags = f;
    #1 chk({tag, ".exctype"}, exctype, code);
    chk({tag, ".busy_T"}, 32'(busy), 32'd0);
    @(negedge clk); mem_valid = 1'b0; mem_excflags = 8'h00;
    #1 chk({tag, ".npv_T1"}, 32'(new_pc_valid), 32'd1);
    chk({tag, ".new_pc"}, new_pc, pc);
    chk({tag, ".flush_T1"}, 32'(flush), 32'd1);
    chk({tag, ".busy_T1"}, 32'(busy), 32'd1);
    @(negedge clk);
    #1 chk({tag, ".npv_T2"}, 32'(new_pc_valid), 32'd0);
    chk({tag, ".flush_T2"}, 32'(flush), 32'd1);
    @(negedge clk);
    #1 chk({tag, ".flush_T3"}, 32'(flush), 32'd0);
    chk({tag, ".busy_T3"}, 32'(busy), 32'd0);
    chk({tag, ".pc_hold"}, new_pc, pc);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b0;
    mem_valid = 1'b0;
    mem_excflags = 8'h00;
    mem_badaddr = 32'h0;
    hw_intr = 6'h00;
    status = 32'h0;
    cause = 32'h0;
    epc = 32'h0;

    // Reset held: inputs toggled, all outputs stay at reset values
    @(negedge clk); mem_valid = 1'b1; mem_excflags = 8'h02; hw_intr = 6'h3f; mem_badaddr = 32'hdead_beef;
    #1 chk("rst.exctype", exctype, 32'h0);
    chk("rst.flush", 32'(flush), 32'd0);
    chk("rst.npv", 32'(new_pc_valid), 32'd0);
    chk("rst.new_pc", new_pc, 32'h0);
    chk("rst.busy", 32'(busy), 32'd0);
    @(negedge clk); mem_excflags = 8'hff;
    @(negedge clk);
    #1 chk("rst.intr", 32'(intr), 32'd0);
    chk("rst.exctype2", exctype, 32'h0);
    mem_valid = 1'b0; mem_excflags = 8'h00; hw_intr = 6'h00;
    @(negedge clk); rst = 1'b1;
    #1 chk("rel.busy", 32'(busy), 32'd0);
    chk("rel.exctype", exctype, 32'h0);

    // RI beats SYS
    accept_chk("ri", 8'h0a, E_RI, VEC);

    // mem_valid low suppresses flag exceptions
    @(negedge clk); mem_excflags = 8'h08;
    #1 chk("novalid.exctype", exctype, 32'h0);
    @(negedge clk); mem_excflags = 8'h00;
    #1 chk("novalid.busy", 32'(busy), 32'd0);

    // Priority among synchronous flags
    accept_chk("p_ff", 8'hff, E_ADEL, VEC);
    accept_chk("p_f0", 8'hf0, E_BP, VEC);
    accept_chk("p_e0", 8'he0, E_ADEL, VEC);
    accept_chk("p_c0", 8'hc0, E_ADES, VEC);

    // Back-to-back: OV ignored while flushing, accepted at T+3
    @(negedge clk); mem_valid = 1'b1; mem_excflags = 8'h08;
    #1 chk("b2b.sys", exctype, E_SYS);
    @(negedge clk); mem_excflags = 8'h04;
    #1 chk("b2b.ov_T1", exctype, 32'h0);
    chk("b2b.npv_T1", 32'(new_pc_valid), 32'd1);
    @(negedge clk);
    #1 chk("b2b.ov_T2", exctype, 32'h0);
    chk("b2b.flush_T2", 32'(flush), 32'd1);
    @(negedge clk);
    #1 chk("b2b.ov_T3", exctype, E_OV);
    chk("b2b.flush_T3", 32'(flush), 32'd0);
    @(negedge clk); mem_valid = 1'b0; mem_excflags = 8'h00;
    #1 chk("b2b.npv_T4", 32'(new_pc_valid), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1 chk("b2b.idle", 32'(busy), 32'd0);

    // Interrupt: two-flop synchroniser latency, then INT beats adel_if
    @(negedge clk); status = 32'h0000_0401; hw_intr = 6'h01;
    #1 chk("int.intr0", 32'(intr), 32'd0);
    @(negedge clk);
    #1 chk("int.intr1", 32'(intr), 32'd0);
    @(negedge clk);
    #1 chk("int.intr2", 32'(intr), 32'h01);
    cause = 32'h0000_0400;
    #1 chk("int.novalid", exctype, 32'h0);
    accept_chk("int", 8'h01, E_INT, VEC);

    // EXL set masks the interrupt
    @(negedge clk); status = 32'h0000_0403; mem_valid = 1'b1; mem_excflags = 8'h00;
    #1 chk("intmask.exctype", exctype, 32'h0);
    @(negedge clk); mem_valid = 1'b0;
    #1 chk("intmask.busy", 32'(busy), 32'd0);
    accept_chk("intmask_adel", 8'h01, E_ADEL, VEC);
    status = 32'h0; cause = 32'h0; hw_intr = 6'h00;

    // ERET redirects to EPC sampled at T
    epc = 32'h8000_1234;
    @(negedge clk); mem_valid = 1'b1; mem_excflags = 8'h80;
    #1 chk("eret.exctype", exctype, E_ERET);
    @(negedge clk); mem_valid = 1'b0; mem_excflags = 8'h00; epc = 32'h0bad_0000;
    #1 chk("eret.npv", 32'(new_pc_valid), 32'd1);
    chk("eret.new_pc", new_pc, 32'h8000_1234);
    @(negedge clk);
    @(negedge clk);
    #1 chk("eret.hold", new_pc, 32'h8000_1234);
    chk("eret.busy", 32'(busy), 32'd0);

    // Reset mid-flush: outputs drop at once, no redirect after release
    @(negedge clk); mem_valid = 1'b1; mem_excflags = 8'h08;
    #1 chk("mrst.sys", exctype, E_SYS);
    @(negedge clk); mem_valid = 1'b0; mem_excflags = 8'h00;
    #1 chk("mrst.npv_pre", 32'(new_pc_valid), 32'd1);
    #1 rst = 1'b0;
    #1 chk("mrst.flush", 32'(flush), 32'd0);
    chk("mrst.npv", 32'(new_pc_valid), 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.new_pc", new_pc, 32'h0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    #1 chk("mrst.npv_after", 32'(new_pc_valid), 32'd0);
    chk("mrst.flush_after", 32'(flush), 32'd0);
    @(negedge clk);
    #1 chk("mrst.npv_after2", 32'(new_pc_valid), 32'd0);
    chk("mrst.busy_after", 32'(busy), 32'd0);

    // Normal operation resumes
    accept_chk("post", 8'h04, E_OV, VEC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
